// File: rtl/fpu_pkg.sv
// Shared definitions for the fp16 compare path: result codes, fp16 field
// widths and the arbiter state encoding.
package fpu_pkg;

  // One-hot compare result codes {lt, gt, eq}
  localparam logic [2:0] CMP_LT   = 3'b100;
  localparam logic [2:0] CMP_GT   = 3'b010;
  localparam logic [2:0] CMP_EQ   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  // fp16 layout {sign, exp[4:0], man[9:0]}
  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;
  localparam int FP16_W = 1 + EXP_W + MAN_W;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // A compare result is well formed only if it is exactly one of the three codes
  function automatic logic is_valid_code(input logic [2:0] code);
    return (code == CMP_LT) || (code == CMP_GT) || (code == CMP_EQ);
  endfunction

endpackage

// File: rtl/fp16_cmp_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright, and on a tie
// the requester that was not served last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant
);

  // Pick the winner from the current valids and the previous owner
  always_comb begin
    grant_valid = |valid;
    grant       = 1'b0;
    case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp16_cmp_arbiter.sv
// Shares one multi-cycle fp16 compare unit between two requesters. Operands
// are latched on accept, a start pulse is issued, and the result (or a
// timeout) is returned as a one-cycle pulse to whoever owned the request.
module fp16_cmp_arbiter
  import fpu_pkg::*;
#(
  parameter int TO_W    = 6,
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  output logic        rsp0_valid,
  output logic [2:0]  rsp0_result,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [2:0]  rsp1_result,
  output logic        rsp1_err,
  output logic        cmp_start,
  output logic [15:0] cmp_x,
  output logic [15:0] cmp_y,
  input  logic        cmp_done,
  input  logic [2:0]  cmp_result
);

  // Last WAIT cycle index before the watchdog fires
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic            last_grant;
  logic            owner;
  logic [TO_W-1:0] cnt;
  logic            grant_valid;
  logic            grant;
  logic [2:0]      fin_result;
  logic            fin_err;

  rr_arb2 u_arb (
    .valid       ({req1_valid, req0_valid}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Ready is only offered in IDLE, to the arbitration winner, outside reset
  assign req0_ready = rst_n && (state == ST_IDLE) && grant_valid && !grant;
  assign req1_ready = rst_n && (state == ST_IDLE) && grant_valid &&  grant;

  // Outcome of a WAIT cycle: a done beats a coincident timeout
  always_comb begin
    fin_result = CMP_NONE;
    fin_err    = 1'b1;
    if (cmp_done) begin
      fin_result = cmp_result;
      fin_err    = !is_valid_code(cmp_result);
    end
  end

  // Sequencing FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      cnt         <= '0;
      cmp_start   <= 1'b0;
      cmp_x       <= '0;
      cmp_y       <= '0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= CMP_NONE;
      rsp0_err    <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= CMP_NONE;
      rsp1_err    <= 1'b0;
    end else begin
      cmp_start  <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            cmp_x     <= grant ? req1_x : req0_x;
            cmp_y     <= grant ? req1_y : req0_y;
            owner     <= grant;
            cmp_start <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cmp_done || (cnt == TO_LAST)) begin
            if (owner) begin
              rsp1_valid  <= 1'b1;
              rsp1_result <= fin_result;
              rsp1_err    <= fin_err;
            end else begin
              rsp0_valid  <= 1'b1;
              rsp0_result <= fin_result;
              rsp0_err    <= fin_err;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          last_grant <= owner;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_cmp_arbiter.sv
// Directed bench for fp16_cmp_arbiter: the compare unit is played by the
// stimulus itself, and every expected value is written out by hand.
module tb_fp16_cmp_arbiter;

  localparam int TIMEOUT = 40;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_x, req0_y, req1_x, req1_y;
  logic        rsp0_valid, rsp1_valid;
  logic [2:0]  rsp0_result, rsp1_result;
  logic        rsp0_err, rsp1_err;
  logic        cmp_start;
  logic [15:0] cmp_x, cmp_y;
  logic        cmp_done;
  logic [2:0]  cmp_result;

  int vectors = 0;
  int miscompares = 0;

  fp16_cmp_arbiter #(.TO_W(6), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_x      (req0_x),
    .req0_y      (req0_y),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_x      (req1_x),
    .req1_y      (req1_y),
    .rsp0_valid  (rsp0_valid),
    .rsp0_result (rsp0_result),
    .rsp0_err    (rsp0_err),
    .rsp1_valid  (rsp1_valid),
    .rsp1_result (rsp1_result),
    .rsp1_err    (rsp1_err),
    .cmp_start   (cmp_start),
    .cmp_x       (cmp_x),
    .cmp_y       (cmp_y),
    .cmp_done    (cmp_done),
    .cmp_result  (cmp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and step slightly past the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Everything the DUT drives must be zero
  task automatic check_all_zero(input string tag);
    #1;
    check_output({tag, " ready0"}, 32'(req0_ready), 32'd0);
    check_output({tag, " ready1"}, 32'(req1_ready), 32'd0);
    check_output({tag, " start"},  32'(cmp_start), 32'd0);
    check_output({tag, " cmp_x"},  32'(cmp_x), 32'd0);
    check_output({tag, " cmp_y"},  32'(cmp_y), 32'd0);
    check_output({tag, " rsp0"},   {rsp0_valid, rsp0_result, rsp0_err}, 32'd0);
    check_output({tag, " rsp1"},   {rsp1_valid, rsp1_result, rsp1_err}, 32'd0);
  endtask

  // Runs one transaction from the IDLE cycle in which requester 'who' must be
  // granted. The compare unit answers 'delay' cycles after start (0 = never).
  task automatic serve(input string tag, input bit who, input logic [15:0] x,
                       input logic [15:0] y, input int delay, input logic [2:0] res,
                       input logic [2:0] exp_res, input logic exp_err,
                       input bit stray_issue);
    int n;
    #1;
    check_output({tag, " own ready"},   32'(who ? req1_ready : req0_ready), 32'd1);
    check_output({tag, " other ready"}, 32'(who ? req0_ready : req1_ready), 32'd0);
    cyc();
    if (who) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (stray_issue) begin
      cmp_done = 1'b1;
      cmp_result = 3'b010;
    end
    #1;
    check_output({tag, " start"}, 32'(cmp_start), 32'd1);
    check_output({tag, " issue ready"}, {req1_ready, req0_ready}, 32'd0);
    check_output({tag, " issue x"}, 32'(cmp_x), 32'(x));
    check_output({tag, " issue y"}, 32'(cmp_y), 32'(y));
    n = (delay == 0) ? TIMEOUT : delay;
    for (int k = 1; k <= n; k++) begin
      cyc();
      cmp_done = 1'b0;
      cmp_result = 3'b000;
      check_output({tag, " wait start"}, 32'(cmp_start), 32'd0);
      check_output({tag, " wait xy"}, {cmp_x, cmp_y}, {x, y});
      check_output({tag, " wait rsp"}, {rsp1_valid, rsp0_valid}, 32'd0);
      if (delay != 0 && k == n) begin
        cmp_done = 1'b1;
        cmp_result = res;
      end
    end
    cyc();
    cmp_done = 1'b0;
    cmp_result = 3'b000;
    if (who) begin
      check_output({tag, " rsp1"}, {rsp1_valid, rsp1_result, rsp1_err}, {1'b1, exp_res, exp_err});
      check_output({tag, " rsp0 quiet"}, 32'(rsp0_valid), 32'd0);
    end else begin
      check_output({tag, " rsp0"}, {rsp0_valid, rsp0_result, rsp0_err}, {1'b1, exp_res, exp_err});
      check_output({tag, " rsp1 quiet"}, 32'(rsp1_valid), 32'd0);
    end
    cyc();
    if (who)
      check_output({tag, " hold1"}, {rsp1_valid, rsp1_result, rsp1_err}, {1'b0, exp_res, exp_err});
    else
      check_output({tag, " hold0"}, {rsp0_valid, rsp0_result, rsp0_err}, {1'b0, exp_res, exp_err});
    check_output({tag, " idle start"}, 32'(cmp_start), 32'd0);
  endtask

  task automatic apply_stimulus();
    // Reset with both requesters already valid
    rst_n = 1'b0;
    cmp_done = 1'b0; cmp_result = 3'b000;
    req0_valid = 1'b1; req0_x = 16'h3C00; req0_y = 16'h4000;
    req1_valid = 1'b1; req1_x = 16'hBC00; req1_y = 16'h3C00;
    cyc();
    cyc();
    check_all_zero("reset");

    // Tie from reset: req0 first (1.0 < 2.0), then req1 (-1.0 < 1.0)
    rst_n = 1'b1;
    serve("tie r0", 1'b0, 16'h3C00, 16'h4000, 3, 3'b100, 3'b100, 1'b0, 1'b0);
    check_output("tie r1 untouched", {rsp1_result, rsp1_err}, 32'd0);
    serve("tie r1", 1'b1, 16'hBC00, 16'h3C00, 1, 3'b100, 3'b100, 1'b0, 1'b0);

    // Second tie alternates again: equal then greater
    req0_valid = 1'b1; req0_x = 16'h4000; req0_y = 16'h4000;
    req1_valid = 1'b1; req1_x = 16'h4000; req1_y = 16'h3C00;
    serve("eq r0", 1'b0, 16'h4000, 16'h4000, 2, 3'b001, 3'b001, 1'b0, 1'b0);
    serve("gt r1", 1'b1, 16'h4000, 16'h3C00, 2, 3'b010, 3'b010, 1'b0, 1'b0);

    // Watchdog expiry, then normal service
    req1_valid = 1'b1; req1_x = 16'h3C00; req1_y = 16'h3C00;
    serve("timeout", 1'b1, 16'h3C00, 16'h3C00, 0, 3'b000, 3'b000, 1'b1, 1'b0);
    req1_valid = 1'b1; req1_x = 16'h3C00; req1_y = 16'h4000;
    serve("after to", 1'b1, 16'h3C00, 16'h4000, 1, 3'b100, 3'b100, 1'b0, 1'b0);

    // Done arriving on the very cycle the watchdog fires wins
    req0_valid = 1'b1; req0_x = 16'h4000; req0_y = 16'h3C00;
    serve("done@to", 1'b0, 16'h4000, 16'h3C00, TIMEOUT, 3'b010, 3'b010, 1'b0, 1'b0);

    // Malformed results, and a done during ISSUE that must be ignored
    req0_valid = 1'b1; req0_x = 16'h4000; req0_y = 16'h4000;
    serve("bad 110", 1'b0, 16'h4000, 16'h4000, 2, 3'b110, 3'b110, 1'b1, 1'b0);
    req1_valid = 1'b1; req1_x = 16'h3C00; req1_y = 16'h4000;
    serve("bad 000", 1'b1, 16'h3C00, 16'h4000, 1, 3'b000, 3'b000, 1'b1, 1'b0);
    req0_valid = 1'b1; req0_x = 16'h3C00; req0_y = 16'h4000;
    serve("stray iss", 1'b0, 16'h3C00, 16'h4000, 2, 3'b100, 3'b100, 1'b0, 1'b1);

    // Stray done while IDLE with nobody requesting
    cmp_done = 1'b1; cmp_result = 3'b100;
    cyc();
    cyc();
    cmp_done = 1'b0; cmp_result = 3'b000;
    check_output("stray idle start", 32'(cmp_start), 32'd0);
    cyc();
    check_output("stray idle rsp", {rsp1_valid, rsp0_valid}, 32'd0);

    // Reset in the middle of WAIT after req0 was last served
    req0_valid = 1'b1; req0_x = 16'h3C00; req0_y = 16'h4000;
    cyc();
    req0_valid = 1'b0;
    cyc();
    cyc();
    check_output("pre-reset xy", {cmp_x, cmp_y}, {16'h3C00, 16'h4000});
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check_all_zero("mid reset");
    cmp_done = 1'b1; cmp_result = 3'b001;
    cyc();
    cmp_done = 1'b0; cmp_result = 3'b000;
    cyc();
    check_output("post reset rsp", {rsp1_valid, rsp0_valid}, 32'd0);

    // Tie after reset goes to req0 again
    req0_valid = 1'b1; req0_x = 16'h4000; req0_y = 16'h3C00;
    req1_valid = 1'b1; req1_x = 16'h3C00; req1_y = 16'h3C00;
    serve("rst tie r0", 1'b0, 16'h4000, 16'h3C00, 1, 3'b010, 3'b010, 1'b0, 1'b0);
    serve("rst tie r1", 1'b1, 16'h3C00, 16'h3C00, 1, 3'b001, 3'b001, 1'b0, 1'b0);
  endtask

  initial begin
    apply_stimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
